lpif_dstrm_arb_x4: RTL and testbench
====================================

# lpif_dstrm_arb_x4

Downstream flit arbiter for the x4 asymmetric LPIF TX path. It shares the single 77-bit downstream LPIF channel (state, protid, 64-bit data, dvalid, 4-bit crc, crc_valid, valid) between two protocol-layer requesters. Grants are round-robin, and a grant stays locked for a whole packet. Its registered dstrm_* outputs feed the LPIF txrx data-mapping block that packs the TX FIFO word.

## Interface
- PROTID0, 2'd0: protid stamped on beats from requester 0
- PROTID1, 2'd1: protid stamped on beats from requester 1
- MAX_BURST, 16: max beats per locked grant (legal range 1..255)

- clk_wr  in  1  link-layer write clock; the only clock
- rst_wr_n  in  1  reset; synchronous, active-low
- lp_state  in  4  current link state to broadcast
- link_ready  in  1  downstream slot consumed this cycle
- req0_valid  in  1  requester 0 beat valid
- req0_data  in  64  requester 0 data
- req0_crc  in  4  requester 0 crc
- req0_crc_valid  in  1  requester 0 crc qualifier
- req0_last  in  1  final beat of requester 0 packet
- req0_ready  out  1  requester 0 beat accepted
- req1_valid, req1_data, req1_crc, req1_crc_valid, req1_last, req1_ready: same as requester 0, for requester 1
- dstrm_state  out  4  registered link state
- dstrm_protid  out  2  protid of current beat
- dstrm_data  out  64  beat data
- dstrm_dvalid  out  1  beat carries data
- dstrm_crc  out  4  beat crc
- dstrm_crc_valid  out  1  crc qualifier
- dstrm_valid  out  1  flit slot valid
- grant_id  out  1  requester currently owning or last owning the channel
- lock  out  1  a packet grant is in progress
- err_burst  out  1  one-cycle pulse: grant force-released at MAX_BURST

## Operation
- FSM states are IDLE, LOCK0 and LOCK1.
- A beat transfers when reqN_valid and reqN_ready are both 1 in the same cycle.
- reqN_ready is combinational. It is 1 only when all of the following hold:
  - link_ready = 1;
  - rst_wr_n = 1;
  - requester N is the current winner.
- Winner rules:
  - IDLE, one requester valid: that requester wins.
  - IDLE, both valid: the requester named by round-robin pointer rr wins.
  - LOCK0 / LOCK1: only the locked requester can win.
- On a transfer:
  - beat counter += 1;
  - if last = 1, or counter reaches MAX_BURST: go to IDLE, clear counter, set rr to the other requester.
  - otherwise: go to / stay in LOCKN.
- A single-beat packet (last = 1 on the first beat) never leaves IDLE; rr still flips.
- Forced release at MAX_BURST without last pulses err_burst for one cycle. The remaining beats of that packet re-arbitrate as a new packet.
- In LOCKN with reqN_valid = 0, the lock is held and idle flits are emitted. The other requester is never served mid-packet.
- Output register load rule, on every clock with link_ready = 1:
  - beat transferred: load that beat. dstrm_dvalid = 1; protid = PROTIDN; data, crc and crc_valid come from the requester.
  - no transfer: load an idle flit. dvalid = 0, crc_valid = 0; data, crc and protid are held.
- With link_ready = 0, data, protid, dvalid, crc and crc_valid hold.
- dstrm_state <= lp_state every cycle, independent of link_ready.
- dstrm_valid <= 1 every cycle after reset.
- grant_id is updated on each transfer. lock = (state != IDLE).
- The beat counter is $clog2(MAX_BURST+1) bits wide and never wraps.

## Timing
- Reset (rst_wr_n = 0 at an edge) sets:
  - all dstrm_* outputs = 0;
  - grant_id = 0, lock = 0, err_burst = 0;
  - state = IDLE, rr = 0 (requester 0 favored), counter = 0.
- Both ready outputs are 0 while rst_wr_n = 0.
- Reset asserted mid-packet abandons the lock. No partial-packet recovery is performed.
- Latency: a beat accepted at edge k appears on dstrm_* after edge k; it is consumed at the first later edge with link_ready = 1.
- Throughput: one beat per cycle while link_ready = 1.
- link_ready = 0 blocks acceptance in the same cycle, with no skid.
- Transfer with last in cycle k: a new arbitration takes place in cycle k+1, with zero bubble.
- err_burst is asserted in the cycle after the forcing transfer.

## Test plan
- Reset: rst_wr_n = 0 for 3 cycles with both requesters valid.
  - During reset: both ready = 0.
  - Outputs: all 0, dstrm_valid = 0.
  - First cycle after release: dstrm_valid = 1, req0_ready = 1.
- Contention: both valid continuously, each sending 2-beat packets (last on beat 2).
  - Required protid sequence: 0,0,1,1,0,0,...
  - Neither requester ever loses its grant mid-packet.
- Lock hold: req0 sends beat 1, then drops valid for 3 cycles while req1 is valid.
  - Required: 3 idle flits (dvalid = 0, dstrm_valid = 1), req1_ready = 0 throughout.
  - req0 then finishes its packet.
- Backpressure: toggle link_ready 1,0,0,1 during a 4-beat req1 packet with data 0xA..0xD.
  - Required: ready = 0 while link_ready = 0.
  - dstrm_data holds its value while link_ready = 0; all 4 beats arrive in order, none duplicated.
- Burst cap: MAX_BURST = 4, req0 sends 6 beats, last only on beat 6, with req1 valid.
  - Required: err_burst pulses after beat 4.
  - Next grant goes to req1; req0's remaining 2 beats follow later.
- State passthrough: step lp_state 0x1, 0x3, 0x8 while link_ready = 0.
  - Required: dstrm_state tracks lp_state one cycle later.
  - dstrm_dvalid stays unchanged.

Source files
------------

// File: rtl/lpif_dstrm_arb_x4_if.sv
// Bundle of requester, downstream LPIF and status signals shared by the x4 TX arbiter.
// The arbiter connects through the slave modport; the driving side uses master.
interface lpif_dstrm_arb_x4_if;
  logic [3:0]  lp_state;
  logic        link_ready;

  logic        req0_valid;
  logic [63:0] req0_data;
  logic [3:0]  req0_crc;
  logic        req0_crc_valid;
  logic        req0_last;
  logic        req0_ready;

  logic        req1_valid;
  logic [63:0] req1_data;
  logic [3:0]  req1_crc;
  logic        req1_crc_valid;
  logic        req1_last;
  logic        req1_ready;

  logic [3:0]  dstrm_state;
  logic [1:0]  dstrm_protid;
  logic [63:0] dstrm_data;
  logic        dstrm_dvalid;
  logic [3:0]  dstrm_crc;
  logic        dstrm_crc_valid;
  logic        dstrm_valid;

  logic        grant_id;
  logic        lock;
  logic        err_burst;

  modport slave (
    input  lp_state, link_ready,
    input  req0_valid, req0_data, req0_crc, req0_crc_valid, req0_last,
    input  req1_valid, req1_data, req1_crc, req1_crc_valid, req1_last,
    output req0_ready, req1_ready,
    output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
    output dstrm_crc, dstrm_crc_valid, dstrm_valid,
    output grant_id, lock, err_burst
  );

  modport master (
    output lp_state, link_ready,
    output req0_valid, req0_data, req0_crc, req0_crc_valid, req0_last,
    output req1_valid, req1_data, req1_crc, req1_crc_valid, req1_last,
    input  req0_ready, req1_ready,
    input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
    input  dstrm_crc, dstrm_crc_valid, dstrm_valid,
    input  grant_id, lock, err_burst
  );
endinterface

// File: rtl/lpif_dstrm_arb_x4.sv
// Two-requester round-robin arbiter for the downstream LPIF channel; a grant is
// held for a whole packet, force-released after MAX_BURST beats.
module lpif_dstrm_arb_x4 #(
  parameter logic [1:0]  PROTID0   = 2'd0,
  parameter logic [1:0]  PROTID1   = 2'd1,
  parameter int unsigned MAX_BURST = 16
) (
  input logic               clk_wr,
  input logic               rst_wr_n,
  lpif_dstrm_arb_x4_if.slave bus
);
  localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rr_q, rr_d;
  logic             grant_q, grant_d;
  logic             err_q, err_d;
  logic             win, win_vld, win_last, slot_ok, xfer, cap;

  logic [3:0]  state_out_q;
  logic [1:0]  protid_q;
  logic [63:0] data_q;
  logic        dvalid_q;
  logic [3:0]  crc_q;
  logic        crc_valid_q;
  logic        valid_q;

  // Winner selection; with no requester valid in IDLE the rr pointer is offered.
  always_comb begin
    win = rr_q;
    case (state_q)
      LOCK0:   win = 1'b0;
      LOCK1:   win = 1'b1;
      default: begin
        if (bus.req0_valid && !bus.req1_valid)      win = 1'b0;
        else if (!bus.req0_valid && bus.req1_valid) win = 1'b1;
        else                                        win = rr_q;
      end
    endcase
  end

  assign slot_ok  = bus.link_ready & rst_wr_n;
  assign win_vld  = win ? bus.req1_valid : bus.req0_valid;
  assign win_last = win ? bus.req1_last  : bus.req0_last;
  assign xfer     = slot_ok & win_vld;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign cap      = (cnt_inc == CNT_MAX);

  assign bus.req0_ready = slot_ok & ~win;
  assign bus.req1_ready = slot_ok &  win;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    err_d   = 1'b0;
    if (xfer) begin
      grant_d = win;
      if (win_last || cap) begin
        state_d = IDLE;
        cnt_d   = '0;
        rr_d    = ~win;
        err_d   = cap & ~win_last;
      end else begin
        state_d = win ? LOCK1 : LOCK0;
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  // Output flit register: beat or idle flit per consumed slot, hold otherwise.
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state_out_q <= '0;
      protid_q    <= '0;
      data_q      <= '0;
      dvalid_q    <= 1'b0;
      crc_q       <= '0;
      crc_valid_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_out_q <= bus.lp_state;
      valid_q     <= 1'b1;
      if (bus.link_ready) begin
        if (xfer) begin
          dvalid_q    <= 1'b1;
          protid_q    <= win ? PROTID1 : PROTID0;
          data_q      <= win ? bus.req1_data : bus.req0_data;
          crc_q       <= win ? bus.req1_crc : bus.req0_crc;
          crc_valid_q <= win ? bus.req1_crc_valid : bus.req0_crc_valid;
        end else begin
          dvalid_q    <= 1'b0;
          crc_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.dstrm_state     = state_out_q;
  assign bus.dstrm_protid    = protid_q;
  assign bus.dstrm_data      = data_q;
  assign bus.dstrm_dvalid    = dvalid_q;
  assign bus.dstrm_crc       = crc_q;
  assign bus.dstrm_crc_valid = crc_valid_q;
  assign bus.dstrm_valid     = valid_q;
  assign bus.grant_id        = grant_q;
  assign bus.lock            = (state_q != IDLE);
  assign bus.err_burst       = err_q;
endmodule

// File: tb/tb_lpif_dstrm_arb_x4.sv
// Directed bench for lpif_dstrm_arb_x4: a per-cycle vector table plus hand-written
// burst-cap and mid-packet reset sequences.
module tb_lpif_dstrm_arb_x4;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  lpif_dstrm_arb_x4_if bus ();

  lpif_dstrm_arb_x4 #(.MAX_BURST(4)) dut (
    .clk_wr   (clk),
    .rst_wr_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        lr;
    logic [3:0]  st;
    logic        v0;
    logic [63:0] d0;
    logic        l0;
    logic        v1;
    logic [63:0] d1;
    logic        l1;
    logic        e_r0;
    logic        e_r1;
    logic        e_dv;
    logic [1:0]  e_pid;
    logic [63:0] e_d;
    logic        e_err;
    logic        e_lock;
  } vec_t;

  vec_t vq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic lr, input logic [3:0] st,
                       input logic v0, input logic [63:0] d0, input logic l0,
                       input logic v1, input logic [63:0] d1, input logic l1);
    rst_n               = rn;
    bus.link_ready      = lr;
    bus.lp_state        = st;
    bus.req0_valid      = v0;
    bus.req0_data       = d0;
    bus.req0_crc        = d0[3:0];
    bus.req0_crc_valid  = v0;
    bus.req0_last       = l0;
    bus.req1_valid      = v1;
    bus.req1_data       = d1;
    bus.req1_crc        = d1[3:0];
    bus.req1_crc_valid  = v1;
    bus.req1_last       = l1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // rst lr st  v0 d0          l0 v1 d1          l1 r0 r1 dv pid d           err lock
    for (int i = 0; i < 3; i++)
      vq.push_back('{0, 1, 4'hF, 1, 64'h100, 0, 1, 64'h200, 0, 0, 0, 0, 2'd0, 64'h0, 0, 0});
    // contention, 2-beat packets
    vq.push_back('{1, 1, 4'h0, 1, 64'h01, 0, 1, 64'h11, 0, 1, 0, 1, 2'd0, 64'h01, 0, 1});
    vq.push_back('{1, 1, 4'h0, 1, 64'h02, 1, 1, 64'h11, 0, 1, 0, 1, 2'd0, 64'h02, 0, 0});
    vq.push_back('{1, 1, 4'h0, 1, 64'h03, 0, 1, 64'h11, 0, 0, 1, 1, 2'd1, 64'h11, 0, 1});
    vq.push_back('{1, 1, 4'h0, 1, 64'h03, 0, 1, 64'h12, 1, 0, 1, 1, 2'd1, 64'h12, 0, 0});
    vq.push_back('{1, 1, 4'h0, 1, 64'h03, 0, 1, 64'h13, 0, 1, 0, 1, 2'd0, 64'h03, 0, 1});
    vq.push_back('{1, 1, 4'h0, 1, 64'h04, 1, 1, 64'h13, 0, 1, 0, 1, 2'd0, 64'h04, 0, 0});
    // lock hold: req0 beat 1, 3 idle cycles with req1 waiting, then final beat
    vq.push_back('{1, 1, 4'h0, 1, 64'h21, 0, 0, 64'h13, 0, 1, 0, 1, 2'd0, 64'h21, 0, 1});
    for (int i = 0; i < 3; i++)
      vq.push_back('{1, 1, 4'h0, 0, 64'h22, 1, 1, 64'h31, 0, 1, 0, 0, 2'd0, 64'h21, 0, 1});
    vq.push_back('{1, 1, 4'h0, 1, 64'h22, 1, 1, 64'h31, 0, 1, 0, 1, 2'd0, 64'h22, 0, 0});
    // backpressure: 4-beat req1 packet, link_ready 1,0,0,1
    vq.push_back('{1, 1, 4'h0, 0, 64'h0, 0, 1, 64'hA, 0, 0, 1, 1, 2'd1, 64'hA, 0, 1});
    vq.push_back('{1, 0, 4'h0, 0, 64'h0, 0, 1, 64'hB, 0, 0, 0, 1, 2'd1, 64'hA, 0, 1});
    vq.push_back('{1, 0, 4'h0, 0, 64'h0, 0, 1, 64'hB, 0, 0, 0, 1, 2'd1, 64'hA, 0, 1});
    vq.push_back('{1, 1, 4'h0, 0, 64'h0, 0, 1, 64'hB, 0, 0, 1, 1, 2'd1, 64'hB, 0, 1});
    vq.push_back('{1, 1, 4'h0, 0, 64'h0, 0, 1, 64'hC, 0, 0, 1, 1, 2'd1, 64'hC, 0, 1});
    vq.push_back('{1, 1, 4'h0, 0, 64'h0, 0, 1, 64'hD, 1, 0, 1, 1, 2'd1, 64'hD, 0, 0});
    // state passthrough with link_ready low
    vq.push_back('{1, 0, 4'h1, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 1, 2'd1, 64'hD, 0, 0});
    vq.push_back('{1, 0, 4'h3, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 1, 2'd1, 64'hD, 0, 0});
    vq.push_back('{1, 0, 4'h8, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 1, 2'd1, 64'hD, 0, 0});
    // idle flit with nobody requesting
    vq.push_back('{1, 1, 4'h0, 0, 64'h0, 0, 0, 64'h0, 0, 1, 0, 0, 2'd1, 64'hD, 0, 0});

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].lr, vq[i].st, vq[i].v0, vq[i].d0, vq[i].l0,
            vq[i].v1, vq[i].d1, vq[i].l1);
      #2;
      chk($sformatf("v%0d req0_ready", i), bus.req0_ready, vq[i].e_r0);
      chk($sformatf("v%0d req1_ready", i), bus.req1_ready, vq[i].e_r1);
      tick();
      chk($sformatf("v%0d dvalid", i),    bus.dstrm_dvalid,    vq[i].e_dv);
      chk($sformatf("v%0d crc_valid", i), bus.dstrm_crc_valid, vq[i].e_dv);
      chk($sformatf("v%0d protid", i),    bus.dstrm_protid,    vq[i].e_pid);
      chk($sformatf("v%0d data", i),      bus.dstrm_data,      vq[i].e_d);
      chk($sformatf("v%0d crc", i),       bus.dstrm_crc,       vq[i].e_d[3:0]);
      chk($sformatf("v%0d err_burst", i), bus.err_burst,       vq[i].e_err);
      chk($sformatf("v%0d lock", i),      bus.lock,            vq[i].e_lock);
      chk($sformatf("v%0d grant_id", i),  bus.grant_id,        vq[i].e_pid[0]);
      chk($sformatf("v%0d dstrm_valid", i), bus.dstrm_valid,   vq[i].rst_n);
      chk($sformatf("v%0d dstrm_state", i), bus.dstrm_state,
          vq[i].rst_n ? vq[i].st : 4'h0);
    end

    // burst cap: 6-beat req0 packet against MAX_BURST=4, req1 waiting with 1 beat
    for (int b = 1; b <= 4; b++) begin
      drive(1, 1, 4'h0, 1, 64'h40 + 64'(b), 0, 1, 64'h77, 1);
      #2;
      chk($sformatf("cap b%0d req0_ready", b), bus.req0_ready, 1'b1);
      chk($sformatf("cap b%0d req1_ready", b), bus.req1_ready, 1'b0);
      tick();
      chk($sformatf("cap b%0d data", b), bus.dstrm_data, 64'h40 + 64'(b));
      chk($sformatf("cap b%0d protid", b), bus.dstrm_protid, 2'd0);
      chk($sformatf("cap b%0d err_burst", b), bus.err_burst, (b == 4) ? 1'b1 : 1'b0);
      chk($sformatf("cap b%0d lock", b), bus.lock, (b == 4) ? 1'b0 : 1'b1);
    end
    drive(1, 1, 4'h0, 1, 64'h45, 0, 1, 64'h77, 1);
    #2;
    chk("cap rearb req1_ready", bus.req1_ready, 1'b1);
    chk("cap rearb req0_ready", bus.req0_ready, 1'b0);
    tick();
    chk("cap rearb protid", bus.dstrm_protid, 2'd1);
    chk("cap rearb data", bus.dstrm_data, 64'h77);
    chk("cap rearb err_burst", bus.err_burst, 1'b0);
    drive(1, 1, 4'h0, 1, 64'h45, 0, 0, 64'h0, 0);
    tick();
    chk("cap b5 data", bus.dstrm_data, 64'h45);
    chk("cap b5 protid", bus.dstrm_protid, 2'd0);
    chk("cap b5 lock", bus.lock, 1'b1);
    drive(1, 1, 4'h0, 1, 64'h46, 1, 0, 64'h0, 0);
    tick();
    chk("cap b6 data", bus.dstrm_data, 64'h46);
    chk("cap b6 lock", bus.lock, 1'b0);
    chk("cap b6 err_burst", bus.err_burst, 1'b0);

    // reset in the middle of a req1 packet abandons the lock and resets rr
    drive(1, 1, 4'h0, 0, 64'h0, 0, 1, 64'h91, 0);
    tick();
    chk("mid lock", bus.lock, 1'b1);
    chk("mid grant_id", bus.grant_id, 1'b1);
    drive(0, 1, 4'h0, 1, 64'h81, 0, 1, 64'h92, 0);
    #2;
    chk("mid rst req0_ready", bus.req0_ready, 1'b0);
    chk("mid rst req1_ready", bus.req1_ready, 1'b0);
    tick();
    chk("mid rst lock", bus.lock, 1'b0);
    chk("mid rst data", bus.dstrm_data, 64'h0);
    drive(1, 1, 4'h0, 1, 64'h81, 0, 1, 64'h92, 0);
    #2;
    chk("post rst req0_ready", bus.req0_ready, 1'b1);
    chk("post rst req1_ready", bus.req1_ready, 1'b0);
    tick();
    chk("post rst data", bus.dstrm_data, 64'h81);
    chk("post rst protid", bus.dstrm_protid, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
